multdiv_ctrl: RTL

//  Sequencing controller in front of the multi-cycle Booth multiplier and the divider.

---
 rtl/multdiv_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/multdiv_ctrl.sv
// Sequencing controller for the multi-cycle multiplier and divider.
// Takes one MULT/DIV request at a time and latches its operands and tag. It pulses the
// start line of the chosen unit and counts that unit's fixed latency. It then captures
// the result and presents it for one cycle.
module multdiv_ctrl #(
  parameter int unsigned MULT_CYCLES = 17,
  parameter int unsigned DIV_CYCLES  = 33,
  parameter int unsigned TAG_W       = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_ctrl_mult,
  input  logic             i_ctrl_div,
  input  logic [31:0]      i_data_operand_a,
  input  logic [31:0]      i_data_operand_b,
  input  logic [TAG_W-1:0] i_tag_in,
  input  logic [63:0]      i_mult_out,
  input  logic [31:0]      i_div_out,
  output logic [31:0]      o_op_a,
  output logic [31:0]      o_op_b,
  output logic             o_mult_start,
  output logic             o_div_start,
  output logic [31:0]      o_data_result,
  output logic             o_data_exception,
  output logic             o_data_result_rdy,
  output logic [TAG_W-1:0] o_tag_out,
  output logic             o_busy,
  output logic             o_req_drop
);

  localparam int unsigned CntW = $clog2(DIV_CYCLES + 2);
  localparam logic [CntW-1:0] MultLast = CntW'(MULT_CYCLES);
  localparam logic [CntW-1:0] DivLast  = CntW'(DIV_CYCLES);
  localparam logic [31:0] IntMin = 32'h8000_0000;

  typedef enum logic [1:0] {StIdle, StMult, StDiv, StDone} state_e;

  state_e            r_state, w_state_d;
  logic [CntW-1:0]   r_cnt;
  logic [31:0]       r_op_a, r_op_b, r_result;
  logic [TAG_W-1:0]  r_tag;
  logic              r_exc, r_mult_start, r_div_start, r_div_zero, r_div_ovf;

  logic w_can_accept, w_accept, w_busy, w_div_only;
  logic w_mult_fin, w_div_fin, w_mult_ovf;

  assign w_can_accept = (r_state == StIdle) || (r_state == StDone);
  assign w_accept     = w_can_accept && (i_ctrl_mult || i_ctrl_div);
  assign w_div_only   = i_ctrl_div && !i_ctrl_mult;
  assign w_busy       = (r_state == StMult) || (r_state == StDiv);
  assign w_mult_fin   = (r_state == StMult) && (r_cnt == MultLast);
  // Divide-by-zero skips the divider entirely and completes one cycle after accept.
  assign w_div_fin    = (r_state == StDiv) && (r_div_zero || (r_cnt == DivLast));
  assign w_mult_ovf   = i_mult_out[63:32] != {32{i_mult_out[31]}};

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state: accept in Idle/Done (MULT wins a tie), finish when the latency expires.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle, StDone: begin
        if (i_ctrl_mult)     w_state_d = StMult;
        else if (i_ctrl_div) w_state_d = StDiv;
        else                 w_state_d = StIdle;
      end
      StMult:  if (w_mult_fin) w_state_d = StDone;
      StDiv:   if (w_div_fin)  w_state_d = StDone;
      default: w_state_d = StIdle;
    endcase
  end

  // Datapath: operand/tag latch, latency counter, start pulses and result capture.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt        <= '0;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_tag        <= '0;
      r_result     <= '0;
      r_exc        <= 1'b0;
      r_mult_start <= 1'b0;
      r_div_start  <= 1'b0;
      r_div_zero   <= 1'b0;
      r_div_ovf    <= 1'b0;
    end else begin
      r_mult_start <= w_accept && i_ctrl_mult;
      r_div_start  <= w_accept && w_div_only && (i_data_operand_b != '0);
      if (w_accept) begin
        r_op_a     <= i_data_operand_a;
        r_op_b     <= i_data_operand_b;
        r_tag      <= i_tag_in;
        r_cnt      <= '0;
        r_div_zero <= w_div_only && (i_data_operand_b == '0);
        r_div_ovf  <= w_div_only && (i_data_operand_a == IntMin) &&
                      (i_data_operand_b == 32'hFFFF_FFFF);
      end else if (w_busy) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_mult_fin) begin
        r_result <= i_mult_out[31:0];
        r_exc    <= w_mult_ovf;
      end else if (w_div_fin) begin
        if (r_div_zero) begin
          r_result <= '0;
          r_exc    <= 1'b1;
        end else if (r_div_ovf) begin
          // INT_MIN / -1 does not fit; report the wrapped value with an exception.
          r_result <= IntMin;
          r_exc    <= 1'b1;
        end else begin
          r_result <= i_div_out;
          r_exc    <= 1'b0;
        end
      end
    end
  end

  // Outputs: result fields only in Done, drop pulse for any request that is not taken.
  always_comb begin
    o_op_a            = r_op_a;
    o_op_b            = r_op_b;
    o_mult_start      = r_mult_start;
    o_div_start       = r_div_start;
    o_busy            = w_busy;
    o_data_result_rdy = (r_state == StDone);
    o_data_result     = (r_state == StDone) ? r_result : '0;
    o_data_exception  = (r_state == StDone) && r_exc;
    o_tag_out         = (r_state == StDone) ? r_tag : '0;
    o_req_drop        = i_rst_n &&
                        ((w_can_accept && i_ctrl_mult && i_ctrl_div) ||
                         (w_busy && (i_ctrl_mult || i_ctrl_div)));
  end

endmodule
